// File: rtl/vga_frame_fetch.sv
// Prefetches RGB332 frame words from SRAM into a small FIFO and serialises them one pixel per clock.
// Output latency 1 clk; one outstanding read at a time, requests throttled by FIFO occupancy.
module vga_frame_fetch #(
  parameter int                    WIDTH      = 12,
  parameter int                    HSIZE      = 800,
  parameter int                    VSIZE      = 600,
  parameter int                    ADDR_WIDTH = 20,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    FIFO_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      hdata,
  input  logic [WIDTH-1:0]      vdata,
  input  logic                  data_enable,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata,
  output logic [7:0]            pixel,
  output logic                  pixel_valid,
  output logic                  underflow
);

  localparam int TOTAL = HSIZE * VSIZE / 4;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int PW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         fetch_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           fifo_cnt;
  logic                  fifo_empty;
  logic                  frame_restart;
  logic                  push, pop, advance, addr_rst;
  logic [31:0]           head;
  logic [7:0]            head_byte;

  assign frame_restart = (hdata == '0) && (vdata == WIDTH'(VSIZE));
  assign fifo_empty    = (fifo_cnt == '0);
  assign head          = fifo_mem[rd_ptr];
  assign pop           = data_enable && (hdata[1:0] == 2'd3) && !fifo_empty && !frame_restart;
  assign mem_req       = (state != S_IDLE);
  assign mem_addr      = addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // A read in flight at frame restart is completed but its data thrown away.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    advance   = 1'b0;
    addr_rst  = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_restart)
          addr_rst = 1'b1;
        else if (fetch_cnt < CW'(TOTAL) && fifo_cnt < (PW+1)'(FIFO_DEPTH))
          state_nxt = S_REQ;
      end
      S_REQ: begin
        if (mem_ack) begin
          state_nxt = S_IDLE;
          if (frame_restart) begin
            addr_rst = 1'b1;
          end else begin
            push    = 1'b1;
            advance = 1'b1;
          end
        end else if (frame_restart) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (mem_ack) begin
          state_nxt = S_IDLE;
          addr_rst  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= BASE_ADDR;
      fetch_cnt <= '0;
    end else begin
      if (addr_rst)     addr_q <= BASE_ADDR;
      else if (advance) addr_q <= addr_q + ADDR_WIDTH'(1);
      if (frame_restart) fetch_cnt <= '0;
      else if (advance)  fetch_cnt <= fetch_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (frame_restart) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_comb begin
    head_byte = 8'h00;
    case (hdata[1:0])
      2'd0: head_byte = head[31:24];
      2'd1: head_byte = head[23:16];
      2'd2: head_byte = head[15:8];
      2'd3: head_byte = head[7:0];
      default: head_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel       <= 8'h00;
      pixel_valid <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      pixel       <= (data_enable && !fifo_empty) ? head_byte : 8'h00;
      pixel_valid <= data_enable;
      if (frame_restart)                   underflow <= 1'b0;
      else if (data_enable && fifo_empty)  underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_frame_fetch.sv
// Randomised-data bench for vga_frame_fetch on a small raster, with a queue-based reference model.
module tb_vga_frame_fetch;
  localparam int WIDTH = 12;
  localparam int HS = 16, VS = 4, HT = 24, VT = 6;
  localparam int AW = 20, DEPTH = 8;
  localparam logic [AW-1:0] BASE = 20'hFFFFC;
  localparam int TOTAL = HS * VS / 4;
  localparam int FRAME = HT * VT;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] hdata, vdata;
  logic             de;
  logic             mem_req, mem_ack;
  logic [AW-1:0]    mem_addr;
  logic [31:0]      mem_rdata;
  logic [7:0]       pixel;
  logic             pixel_valid, underflow;

  vga_frame_fetch #(.WIDTH(WIDTH), .HSIZE(HS), .VSIZE(VS), .ADDR_WIDTH(AW),
                    .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .hdata(hdata), .vdata(vdata), .data_enable(de),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pixel(pixel), .pixel_valid(pixel_valid), .underflow(underflow));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // reference model state
  logic [31:0]   q[$];
  int            fetched, frame_pushes, epoch, drains;
  bit            exp_uf;
  bit            out_valid;
  int            out_epoch;
  logic [AW-1:0] out_addr;
  // SRAM model and raster generator
  int  lat, wait_c;
  bit  busy;
  int  h, v;
  bit  run, chk_frame, chk_uf, chk_first;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_timing();
    hdata = WIDTH'(h);
    vdata = WIDTH'(v);
    de    = (h < HS) && (v < VS);
  endtask

  task automatic tick();
    bit            fr;
    logic [7:0]    ep;
    logic [31:0]   w;
    logic [31:0]   fw;
    logic [AW-1:0] ea;
    fr = (hdata == 0) && (vdata == WIDTH'(VS));
    if (fr && chk_frame) begin
      check("frame_reads", 32'(frame_pushes), 32'(TOTAL));
      check("frame_no_underflow", 32'(underflow), 32'd0);
    end
    if (fr && chk_uf) check("underflow_set", 32'(underflow), 32'd1);
    @(posedge clk);
    #1;
    ep = 8'h00;
    if (de) begin
      if (q.size() > 0) begin
        w  = q[0];
        ep = w[31 - 8*int'(hdata[1:0]) -: 8];
      end else begin
        exp_uf = 1'b1;
      end
    end
    if (de && hdata[1:0] == 2'd3 && q.size() > 0) void'(q.pop_front());
    if (mem_ack) begin
      if (fr || out_epoch != epoch) begin
        drains++;
      end else begin
        q.push_back(mem_rdata);
        fetched++;
        frame_pushes++;
        check("fifo_bound", 32'(q.size() <= DEPTH), 32'd1);
      end
    end
    if (fr) begin
      q.delete();
      exp_uf = 1'b0;
      fetched = 0;
      frame_pushes = 0;
      epoch++;
    end
    check("pixel", 32'(pixel), 32'(ep));
    check("pixel_valid", 32'(pixel_valid), 32'(de));
    check("underflow", 32'(underflow), 32'(exp_uf));
    if (chk_first && vdata == 0 && hdata < 4) begin
      fw = 32'h11223344;
      check("first_word_byte", 32'(pixel), 32'(fw[31 - 8*int'(hdata[1:0]) -: 8]));
    end
    if (mem_req) begin
      if (!out_valid) begin
        out_valid = 1'b1;
        out_addr  = mem_addr;
        out_epoch = epoch;
        ea = BASE + AW'(fetched);
        check("req_addr", 32'(mem_addr), 32'(ea));
        check("req_budget", 32'(fetched < TOTAL), 32'd1);
      end else begin
        check("addr_hold", 32'(mem_addr), 32'(out_addr));
      end
    end else begin
      out_valid = 1'b0;
    end
    mem_ack = 1'b0;
    if (!busy && mem_req) begin
      busy   = 1'b1;
      wait_c = lat;
    end
    if (busy) begin
      if (wait_c == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = (mem_addr == BASE) ? 32'h11223344 : $urandom;
        busy      = 1'b0;
      end else begin
        wait_c--;
      end
    end
    if (run) begin
      h++;
      if (h == HT) begin
        h = 0;
        v++;
        if (v == VT) v = 0;
      end
    end
    drive_timing();
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to_fr();
    int n;
    n = 0;
    while (!(hdata == 0 && vdata == WIDTH'(VS)) && n < 2*FRAME) begin
      tick();
      n++;
    end
    check("fr_reached", 32'(n < 2*FRAME), 32'd1);
  endtask

  task automatic reset_model();
    q.delete();
    fetched = 0; frame_pushes = 0; epoch++;
    exp_uf = 1'b0; out_valid = 1'b0; busy = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    epoch = 0; drains = 0; out_epoch = 0; out_addr = '0;
    lat = 0; wait_c = 0;
    run = 1'b0; chk_frame = 1'b0; chk_uf = 1'b0; chk_first = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    h = 1; v = VS;
    drive_timing();
    reset_model();
    #12;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'(BASE));
    check("rst_pixel", 32'(pixel), 32'd0);
    check("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // raster frozen in blanking: FIFO fills to depth, then requests stop
    run_cycles(60);
    check("fill_count", 32'(fetched), 32'(DEPTH));
    check("fill_req_idle", 32'(mem_req), 32'd0);

    // start raster at frame restart, fast SRAM then 3-clock ack latency
    h = 0; v = VS; run = 1'b1;
    drive_timing();
    tick();
    chk_frame = 1'b1;
    chk_first = 1'b1;
    run_cycles(2*FRAME);
    lat = 2;
    run_cycles(2*FRAME);

    // slow SRAM: underflow must appear, then clear at frame restart
    chk_frame = 1'b0;
    chk_first = 1'b0;
    lat = 10;
    run_cycles(FRAME);
    chk_uf = 1'b1;
    run_cycles(FRAME);
    chk_uf = 1'b0;
    check("uf_cleared_by_fr", 32'(underflow), 32'd0);
    check("drain_seen", 32'(drains > 0), 32'd1);

    // reset pulse mid-line
    lat = 0;
    run_cycles(FRAME + 2*HT + 6);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check("mid_rst_mem_addr", 32'(mem_addr), 32'(BASE));
    check("mid_rst_pixel", 32'(pixel), 32'd0);
    check("mid_rst_pixel_valid", 32'(pixel_valid), 32'd0);
    check("mid_rst_underflow", 32'(underflow), 32'd0);
    reset_model();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    run_to_fr();
    tick();
    chk_frame = 1'b1;
    chk_first = 1'b1;
    run_cycles(2*FRAME);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
